// File: rtl/game_pkg.sv
// Shared definitions for the hit-or-miss game blocks: round states,
// difficulty ceiling and the LFSR feedback polynomial.
package game_pkg;

    // Round state of the judge.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        WINDOW = 2'd2,
        OVER   = 2'd3
    } game_state_t;

    // Highest difficulty level understood by the tick generator.
    localparam logic [2:0] DIFF_MAX = 3'd4;

    // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 on a left-shifting
    // register whose bit 7 is the oldest bit: taps at bits 7, 5, 4, 3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // One shift of the 8-bit Fibonacci LFSR.
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

    // 8-bit increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR. Loads the seed while reset is low and
// shifts every cycle otherwise. A zero seed would lock the register at zero,
// so callers must supply a nonzero seed.
module lfsr8
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] q_reg;

    // Seed on reset, otherwise advance one step per clock.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg <= seed;
        end else begin
            q_reg <= lfsr_step(q_reg);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/hit_judge.sv
// Round judge for the hit-or-miss game. Lights a pseudo-random lamp on each
// tick, scores the player's button edge as a hit or a miss, raises the
// difficulty after a streak of hits and ends the game after MAX_MISSES misses.
module hit_judge
    import game_pkg::*;
#(
    parameter int         NUM_TARGETS   = 4,     // 2, 4 or 8
    parameter int         LEVEL_UP_HITS = 4,     // 1..255
    parameter int         MAX_MISSES    = 3,     // 1..7
    parameter logic [7:0] LFSR_SEED     = 8'hA5  // nonzero
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   start,
    input  logic [NUM_TARGETS-1:0] btn,
    output logic [NUM_TARGETS-1:0] target,
    output logic [2:0]             difficulty,
    output logic [7:0]             score,
    output logic [2:0]             misses,
    output logic                   hit,
    output logic                   miss,
    output logic                   game_over
);

    localparam int         IDX_W      = $clog2(NUM_TARGETS);
    localparam logic [7:0] LEVEL_UP_K = 8'(LEVEL_UP_HITS);
    localparam logic [2:0] MAX_MISS_K = 3'(MAX_MISSES);

    // ------------------------------------------------------------------
    // Pseudo-random target source
    // ------------------------------------------------------------------
    logic [7:0]             lfsr_q;
    logic [NUM_TARGETS-1:0] lit_onehot;
    logic                   lfsr_unused;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr_q)
    );

    // Decode the low LFSR bits into the lamp that would light on a tick.
    for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_onehot
        assign lit_onehot[gi] = (lfsr_q[IDX_W-1:0] == IDX_W'(gi));
    end

    // Only the low index bits select a lamp; the rest just keep the
    // sequence long.
    assign lfsr_unused = ^lfsr_q[7:IDX_W];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    game_state_t            state_reg,  state_next;
    logic [NUM_TARGETS-1:0] btn_q_reg;
    logic [NUM_TARGETS-1:0] target_reg, target_next;
    logic [2:0]             diff_reg,   diff_next;
    logic [7:0]             score_reg,  score_next;
    logic [2:0]             misses_reg, misses_next;
    logic [7:0]             streak_reg, streak_next;
    logic                   hit_reg,    hit_next;
    logic                   miss_reg,   miss_next;

    logic [NUM_TARGETS-1:0] press;
    logic [2:0]             misses_inc;
    logic [7:0]             streak_inc;

    // Rising edges only: a held button is one press, not one per cycle.
    assign press      = btn & ~btn_q_reg;
    assign misses_inc = misses_reg + 3'd1;
    assign streak_inc = streak_reg + 8'd1;

    // Button history is tracked in every state so a button already held
    // when a lamp lights cannot count as a fresh press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_q_reg <= '0;
        end else begin
            btn_q_reg <= btn;
        end
    end

    // Round state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            target_reg <= '0;
            diff_reg   <= '0;
            score_reg  <= '0;
            misses_reg <= '0;
            streak_reg <= '0;
            hit_reg    <= 1'b0;
            miss_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
            diff_reg   <= diff_next;
            score_reg  <= score_next;
            misses_reg <= misses_next;
            streak_reg <= streak_next;
            hit_reg    <= hit_next;
            miss_reg   <= miss_next;
        end
    end

    // Next-state and judging logic; hit/miss are pulses so they default low.
    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        diff_next   = diff_reg;
        score_next  = score_reg;
        misses_next = misses_reg;
        streak_next = streak_reg;
        hit_next    = 1'b0;
        miss_next   = 1'b0;

        case (state_reg)
            IDLE, OVER: begin
                target_next = '0;
                if (start) begin
                    score_next  = '0;
                    misses_next = '0;
                    streak_next = '0;
                    diff_next   = '0;
                    state_next  = ARMED;
                end
            end

            ARMED: begin
                target_next = '0;
                if (tick) begin
                    target_next = lit_onehot;
                    state_next  = WINDOW;
                end
            end

            WINDOW: begin
                // target_reg is never zero here, so a zero press cannot
                // match it; a correct press beats a simultaneous tick.
                if (press == target_reg) begin
                    hit_next    = 1'b1;
                    score_next  = sat_inc8(score_reg);
                    target_next = '0;
                    state_next  = ARMED;
                    if (streak_inc == LEVEL_UP_K) begin
                        streak_next = '0;
                        if (diff_reg < DIFF_MAX) begin
                            diff_next = diff_reg + 3'd1;
                        end
                    end else begin
                        streak_next = streak_inc;
                    end
                end else if ((press != '0) || tick) begin
                    // Wrong button, several buttons at once, or timeout.
                    miss_next   = 1'b1;
                    misses_next = misses_inc;
                    streak_next = '0;
                    target_next = '0;
                    state_next  = (misses_inc == MAX_MISS_K) ? OVER : ARMED;
                end
            end

            default: begin
                target_next = '0;
                state_next  = IDLE;
            end
        endcase
    end

    assign target     = target_reg;
    assign difficulty = diff_reg;
    assign score      = score_reg;
    assign misses     = misses_reg;
    assign hit        = hit_reg;
    assign miss       = miss_reg;
    assign game_over  = (state_reg == OVER);

endmodule

// File: doc/hit_judge.md
# hit_judge

Game-round judge for the hit-or-miss game. It consumes the `freq` tick strobe from the difficulty tick generator. On each tick it lights one pseudo-random target, then scores the player's button response as a hit or a miss. It closes the loop by driving the tick generator's `difficulty` input, raising the level after a streak of hits, and ends the game after a fixed number of misses.

## Interface
- `NUM_TARGETS`, default 4: number of lamps/buttons; must be 2, 4 or 8.
- `LEVEL_UP_HITS`, default 4: consecutive hits needed to raise difficulty.
- `MAX_MISSES`, default 3: misses that end the game (1..7).
- `LFSR_SEED`, default 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  reset, synchronous, active-low.
- `tick`  in  1  strobe from tick generator; each high cycle counts as one tick.
- `start`  in  1  start/restart request; acted on only in IDLE and OVER.
- `btn`  in  NUM_TARGETS  button levels, already synchronised to `clk`.
- `target`  out  NUM_TARGETS  one-hot lit lamp; all zero when none is lit.
- `difficulty`  out  3  level 0..4, feeds the tick generator.
- `score`  out  8  hit count, saturating at 255.
- `misses`  out  3  miss count.
- `hit`  out  1  one-cycle pulse per hit.
- `miss`  out  1  one-cycle pulse per miss.
- `game_over`  out  1  high while in OVER.

## Operation
- Reset (`rst`=0 at a clock edge):
  - state=IDLE; all outputs 0; LFSR=LFSR_SEED; streak=0; `btn_q`=0.
- Edge detect: `press = btn & ~btn_q`, where `btn_q` is `btn` registered every cycle.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifts every cycle in every state. Target index = LFSR[log2(NUM_TARGETS)-1:0].
- States:
  - IDLE: `target`=0. `start` clears score, misses, streak and difficulty → ARMED.
  - ARMED: `target`=0. `tick` latches the one-hot of the current LFSR index into `target` → WINDOW.
  - WINDOW, priority order:
    - (a) `press` equals `target` exactly → hit: score+1 (saturate), streak+1. If streak+1 == LEVEL_UP_HITS: difficulty+1 when below 4 (otherwise held at 4), and streak=0. Then `target`=0 → ARMED.
    - (b) `press` nonzero but not equal to `target` (wrong button, or several buttons in one cycle) → miss.
    - (c) `tick` with no press → miss (timeout).
    - On any miss: misses+1, streak=0, `target`=0. If the new misses == MAX_MISSES → OVER, else → ARMED.
  - OVER: `target`=0, `game_over`=1. `start` behaves as in IDLE → ARMED.
- Any press in IDLE, ARMED or OVER is ignored.
- `start` in ARMED or WINDOW is ignored.
- Score saturates at 255; misses never exceed MAX_MISSES.

## Timing
- `target` becomes valid on the clock edge that samples `tick` in ARMED, i.e. one cycle after the tick.
- A `btn` rising edge sampled at edge N is judged at edge N:
  - `hit`/`miss`, `score`, `misses` and `difficulty` update at edge N.
  - `target` clears at edge N.
- `tick` and a correct press in the same cycle: the hit wins.
- A timeout miss returns to ARMED, so the next target appears on the following tick. At least one tick is left dark between targets.
- `hit` and `miss` are never high together, and each is high for exactly one cycle.
- `rst` low mid-round overrides everything at that edge.
- Back-to-back ticks (difficulty 4: every other cycle) must be handled with no lost events.

## Structure
- Shared package `game_pkg` holds:
  - state enum {IDLE, ARMED, WINDOW, OVER};
  - `DIFF_MAX`=3'd4;
  - LFSR tap constant.
- The tick generator imports `DIFF_MAX` from the same package.
- Sub-module `lfsr8` (clk, rst, seed, q[7:0]) is free-running and reused by other game blocks.
- The judge FSM, counters and edge detect stay in `hit_judge`.

## Test plan
- Reset then `start`, tick, press the lit button the next cycle → `hit`=1 for 1 cycle, score=1, target=0, state ARMED.
- 4 consecutive hits from difficulty 0 → difficulty=1, streak cleared. 20 hits → difficulty stays 4.
- Target lit, then tick with no press, three rounds in a row → three `miss` pulses, misses=3, `game_over`=1. `start` then → score=0, misses=0, difficulty=0.
- Target 4'b0010, `btn`=4'b0011 rising together → miss (multi-press). Repeat with `btn`=4'b0100 → miss.
- Correct press and `tick` in the same cycle → hit, not miss. Button held high across the next target → no second hit until it is released and pressed again.
- Score preloaded by 255 hits, then another hit → score stays 255. `rst`=0 during WINDOW → all outputs 0 at the next edge.
